// File: rtl/fetch_pkg.sv
// Shared state encoding, opcode/NOP constants and IF/ID payload type for the fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    RST_WAIT = 2'd0,
    WAIT     = 2'd1,
    HOLD     = 2'd2
  } fetch_state_t;

  localparam logic [6:0]  OPC_JAL = 7'b1101111;
  localparam logic [31:0] NOP_INS = 32'h0000_0013;
  localparam int          CNT_W   = 3;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
    logic        pred_taken;
  } id_payload_t;

  // Sign-extended J-type immediate (bit 0 is always zero).
  function automatic logic [31:0] j_imm(input logic [31:0] ins);
    return {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/jal_predecoder.sv
// Combinational JAL detector: flags a JAL opcode and computes PC + J-immediate.
module jal_predecoder
  import fetch_pkg::*;
(
  input  logic [31:0] i_ins,
  input  logic [31:0] i_pc,
  output logic        o_is_jal,
  output logic [31:0] o_target
);

  assign o_is_jal = (i_ins[6:0] == OPC_JAL);
  assign o_target = i_pc + j_imm(i_ins);

endmodule

// File: rtl/fetch_stage.sv
// Fetch-stage PC sequencer and IF/ID holding register with redirect override.
// Optional JAL predecode is enabled by defining FETCH_PREDECODE_EN.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned FETCH_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc_out,
  input  logic [31:0] buf_ins,
  input  logic        buf_valid,
  input  logic        buf_busy,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_ins,
  output logic [31:0] id_pc,
  output logic        id_pred_taken,
  output logic        pc_misalign
);

  // FETCH_LAT must lie in 1..7 so the last count fits the 3-bit settle counter.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FETCH_LAT - 1);

  fetch_state_t     r_state;
  fetch_state_t     w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [31:0]      r_pc_out;
  logic [31:0]      w_pc_next;
  id_payload_t      r_id;
  id_payload_t      w_id_next;
  logic             r_id_valid;
  logic             w_id_valid_next;
  logic             r_misalign;
  logic             w_misalign_next;

  logic             w_clean;
  logic             w_is_jal;
  logic [31:0]      w_pc_plus4;
  logic [31:0]      w_jal_target;
  logic [31:0]      w_seq_pc;

  assign w_clean    = buf_valid && !buf_busy;
  assign w_pc_plus4 = r_pc_out + 32'd4;

`ifdef FETCH_PREDECODE_EN
  jal_predecoder u_jal_predecoder (
    .i_ins    (buf_ins),
    .i_pc     (r_pc_out),
    .o_is_jal (w_is_jal),
    .o_target (w_jal_target)
  );
`else
  assign w_is_jal     = 1'b0;
  assign w_jal_target = w_pc_plus4;
`endif

  assign w_seq_pc = w_is_jal ? w_jal_target : w_pc_plus4;

  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_pc_next       = r_pc_out;
    w_id_next       = r_id;
    w_id_valid_next = r_id_valid;
    w_misalign_next = 1'b0;

    if (redirect_valid) begin
      // A simultaneous handshake still completes for decode; our own next PC is dropped.
      w_state_next         = WAIT;
      w_cnt_next           = '0;
      w_pc_next            = {redirect_pc[31:2], 2'b00};
      w_id_valid_next      = 1'b0;
      w_id_next.pred_taken = 1'b0;
      w_misalign_next      = |redirect_pc[1:0];
    end else begin
      case (r_state)
        RST_WAIT: begin
          w_state_next = WAIT;
        end
        WAIT: begin
          if (!w_clean) begin
            w_cnt_next = '0;
          end else if (r_cnt == CNT_LAST) begin
            w_id_next.ins        = buf_ins;
            w_id_next.pc         = r_pc_out;
            w_id_next.pred_taken = w_is_jal;
            w_id_valid_next      = 1'b1;
            w_pc_next            = w_seq_pc;
            w_cnt_next           = '0;
            w_state_next         = HOLD;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (r_id_valid && id_ready) begin
            w_id_valid_next      = 1'b0;
            w_id_next.pred_taken = 1'b0;
            w_cnt_next           = '0;
            w_state_next         = WAIT;
          end
        end
        default: begin
          w_state_next = RST_WAIT;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RST_WAIT;
      r_cnt      <= '0;
      r_pc_out   <= RESET_PC;
      r_id       <= '{ins: NOP_INS, pc: 32'h0, pred_taken: 1'b0};
      r_id_valid <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_pc_out   <= w_pc_next;
      r_id       <= w_id_next;
      r_id_valid <= w_id_valid_next;
      r_misalign <= w_misalign_next;
    end
  end

  assign pc_out        = r_pc_out;
  assign id_valid      = r_id_valid;
  assign id_ins        = r_id.ins;
  assign id_pc         = r_id.pc;
  assign id_pred_taken = r_id.pred_taken;
  assign pc_misalign   = r_misalign;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, corner sequences and
// randomized traffic against a transaction-level reference model.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          FETCH_LAT = 2;
`ifdef FETCH_PREDECODE_EN
  localparam bit PRED_EN = 1'b1;
`else
  localparam bit PRED_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_out;
  logic [31:0] buf_ins;
  logic        buf_valid;
  logic        buf_busy;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_ins;
  logic [31:0] id_pc;
  logic        id_pred_taken;
  logic        pc_misalign;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RESET_PC), .FETCH_LAT(FETCH_LAT)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_out         (pc_out),
    .buf_ins        (buf_ins),
    .buf_valid      (buf_valid),
    .buf_busy       (buf_busy),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_ins         (id_ins),
    .id_pc          (id_pc),
    .id_pred_taken  (id_pred_taken),
    .pc_misalign    (pc_misalign)
  );

  int checks = 0;
  int errors = 0;
  int xfers  = 0;

  // Reference model: fetch PC, run of clean buffer cycles, and the one-deep IF/ID slot.
  logic [31:0] m_pc;
  logic [31:0] m_ins;
  logic [31:0] m_ipc;
  bit          m_holding;
  bit          m_pred;
  bit          m_mis;
  bit          m_boot;
  int          m_streak;

  typedef struct {
    bit          rst;
    bit          bv;
    bit          bb;
    logic [31:0] bi;
    bit          rv;
    logic [31:0] rpc;
    bit          rdy;
    logic [31:0] e_pc;
    bit          e_v;
    logic [31:0] e_ins;
    logic [31:0] e_ipc;
    bit          e_mis;
  } vec_t;

  vec_t vt[23];

  function automatic vec_t mk(bit r, bit bb, logic [31:0] bi, bit rv, logic [31:0] rpc, bit rdy,
                              logic [31:0] e_pc, bit e_v, logic [31:0] e_ins, logic [31:0] e_ipc,
                              bit e_mis);
    vec_t v;
    v.rst = r;  v.bv = 1'b1; v.bb = bb; v.bi = bi; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
    v.e_pc = e_pc; v.e_v = e_v; v.e_ins = e_ins; v.e_ipc = e_ipc; v.e_mis = e_mis;
    return v;
  endfunction

  function automatic logic [31:0] jal_offset(input logic [31:0] ins);
    logic signed [20:0] off;
    off = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    return 32'(int'(off));
  endfunction

  function automatic void model_update();
    if (rst) begin
      m_pc = RESET_PC; m_ins = 32'h13; m_ipc = 0; m_holding = 0; m_pred = 0;
      m_mis = 0; m_boot = 1; m_streak = 0;
    end else begin
      m_mis = 0;
      if (redirect_valid) begin
        m_pc = redirect_pc & ~32'd3;
        m_holding = 0; m_pred = 0; m_streak = 0; m_boot = 0;
        m_mis = (redirect_pc % 4) != 0;
      end else if (m_boot) begin
        m_boot = 0;
      end else if (m_holding) begin
        if (id_ready) begin
          m_holding = 0; m_pred = 0; m_streak = 0;
        end
      end else if (buf_valid && !buf_busy) begin
        m_streak++;
        if (m_streak == FETCH_LAT) begin
          m_ins = buf_ins; m_ipc = m_pc; m_holding = 1; m_streak = 0;
          m_pred = PRED_EN && (buf_ins[6:0] == 7'h6F);
          m_pc = m_pred ? m_pc + jal_offset(buf_ins) : m_pc + 32'd4;
        end
      end else begin
        m_streak = 0;
      end
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
    end
  endtask

  // One clock: advance model on the edge, then compare every output 1 time unit later.
  task automatic step(input string tag);
    bit          xfer;
    logic [31:0] x_pc;
    logic [31:0] x_ins;
    xfer  = id_valid && id_ready && !rst;
    x_pc  = id_pc;
    x_ins = id_ins;
    @(posedge clk);
    model_update();
    #1;
    chk({tag, "/pc_out"}, pc_out, m_pc);
    chk({tag, "/id_valid"}, 32'(id_valid), 32'(m_holding));
    chk({tag, "/id_ins"}, id_ins, m_ins);
    chk({tag, "/id_pc"}, id_pc, m_ipc);
    chk({tag, "/id_pred_taken"}, 32'(id_pred_taken), 32'(m_pred));
    chk({tag, "/pc_misalign"}, 32'(pc_misalign), 32'(m_mis));
    if (xfer) begin
      xfers++;
      $display("XFER %0d [%s] id_pc=%08h id_ins=%08h", xfers, tag, x_pc, x_ins);
    end
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!id_valid && n < 10) begin
      step(tag);
      n++;
    end
    chk({tag, "/wait_timeout"}, 32'(id_valid), 32'd1);
  endtask

  initial begin
    logic [31:0] r;

    vt[0]  = mk(1, 0, 32'h13,       0, 0,            1, 32'h0,        0, 32'h13,       32'h0,   0);
    vt[1]  = mk(1, 0, 32'h13,       0, 0,            1, 32'h0,        0, 32'h13,       32'h0,   0);
    vt[2]  = mk(1, 0, 32'h13,       0, 0,            1, 32'h0,        0, 32'h13,       32'h0,   0);
    vt[3]  = mk(0, 0, 32'h13,       0, 0,            1, 32'h0,        0, 32'h13,       32'h0,   0);
    vt[4]  = mk(0, 0, 32'h13,       0, 0,            1, 32'h0,        0, 32'h13,       32'h0,   0);
    vt[5]  = mk(0, 0, 32'h00A00093, 0, 0,            1, 32'h4,        1, 32'h00A00093, 32'h0,   0);
    vt[6]  = mk(0, 0, 32'h13,       0, 0,            1, 32'h4,        0, 32'h00A00093, 32'h0,   0);
    vt[7]  = mk(0, 0, 32'h13,       0, 0,            1, 32'h4,        0, 32'h00A00093, 32'h0,   0);
    vt[8]  = mk(0, 0, 32'h00B00113, 0, 0,            0, 32'h8,        1, 32'h00B00113, 32'h4,   0);
    vt[9]  = mk(0, 0, 32'h13,       0, 0,            0, 32'h8,        1, 32'h00B00113, 32'h4,   0);
    vt[10] = mk(0, 1, 32'h13,       0, 0,            0, 32'h8,        1, 32'h00B00113, 32'h4,   0);
    vt[11] = mk(0, 0, 32'h13,       0, 0,            1, 32'h8,        0, 32'h00B00113, 32'h4,   0);
    vt[12] = mk(0, 0, 32'h13,       0, 0,            1, 32'h8,        0, 32'h00B00113, 32'h4,   0);
    vt[13] = mk(0, 1, 32'h13,       0, 0,            1, 32'h8,        0, 32'h00B00113, 32'h4,   0);
    vt[14] = mk(0, 0, 32'h13,       0, 0,            1, 32'h8,        0, 32'h00B00113, 32'h4,   0);
    vt[15] = mk(0, 0, 32'h00C00193, 0, 0,            0, 32'hC,        1, 32'h00C00193, 32'h8,   0);
    vt[16] = mk(0, 0, 32'h13,       1, 32'h103,      0, 32'h100,      0, 32'h00C00193, 32'h8,   1);
    vt[17] = mk(0, 0, 32'h13,       0, 0,            0, 32'h100,      0, 32'h00C00193, 32'h8,   0);
    vt[18] = mk(0, 0, 32'h00D00213, 0, 0,            0, 32'h104,      1, 32'h00D00213, 32'h100, 0);
    vt[19] = mk(0, 0, 32'h13,       1, 32'hFFFFFFFC, 1, 32'hFFFFFFFC, 0, 32'h00D00213, 32'h100, 0);
    vt[20] = mk(0, 0, 32'h13,       0, 0,            1, 32'hFFFFFFFC, 0, 32'h00D00213, 32'h100, 0);
    vt[21] = mk(0, 0, 32'h13,       0, 0,            1, 32'h0,        1, 32'h13,       32'hFFFFFFFC, 0);
    vt[22] = mk(0, 0, 32'h13,       0, 0,            1, 32'h0,        0, 32'h13,       32'hFFFFFFFC, 0);

    rst = 1; buf_valid = 1; buf_busy = 0; buf_ins = 32'h13;
    redirect_valid = 0; redirect_pc = 0; id_ready = 1;

    for (int i = 0; i < 23; i++) begin
      rst = vt[i].rst; buf_valid = vt[i].bv; buf_busy = vt[i].bb; buf_ins = vt[i].bi;
      redirect_valid = vt[i].rv; redirect_pc = vt[i].rpc; id_ready = vt[i].rdy;
      step($sformatf("vec%0d", i));
      chk($sformatf("vec%0d/tbl_pc_out", i), pc_out, vt[i].e_pc);
      chk($sformatf("vec%0d/tbl_id_valid", i), 32'(id_valid), 32'(vt[i].e_v));
      chk($sformatf("vec%0d/tbl_id_ins", i), id_ins, vt[i].e_ins);
      chk($sformatf("vec%0d/tbl_id_pc", i), id_pc, vt[i].e_ipc);
      chk($sformatf("vec%0d/tbl_misalign", i), 32'(pc_misalign), 32'(vt[i].e_mis));
    end

    // Backpressure: five stalled cycles in HOLD, then exactly one handshake.
    redirect_valid = 0; buf_busy = 0; buf_ins = 32'h00100093; id_ready = 0;
    wait_valid("bp_fill");
    for (int i = 0; i < 5; i++) begin
      step("bp_stall");
      chk("bp_stall/id_valid", 32'(id_valid), 32'd1);
      chk("bp_stall/id_ins", id_ins, 32'h00100093);
      chk("bp_stall/id_pc", id_pc, 32'h0);
      chk("bp_stall/pc_out", pc_out, 32'h4);
    end
    id_ready = 1;
    step("bp_release");
    chk("bp_release/id_valid", 32'(id_valid), 32'd0);

    // Predecode: JAL captured at PC 0x10.
    redirect_valid = 1; redirect_pc = 32'h10; buf_ins = 32'h0080006F; id_ready = 0;
    step("pd_redirect");
    redirect_valid = 0;
    wait_valid("pd_fill");
    chk("pd/id_pc", id_pc, 32'h10);
    chk("pd/id_pred_taken", 32'(id_pred_taken), 32'(PRED_EN));
    chk("pd/pc_out", pc_out, PRED_EN ? 32'h18 : 32'h14);
    id_ready = 1;
    step("pd_accept");
    buf_ins = 32'h13;
    wait_valid("pd_next");
    chk("pd_next/id_pc", id_pc, PRED_EN ? 32'h18 : 32'h14);
    chk("pd_next/id_pred_taken", 32'(id_pred_taken), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst            = ($urandom_range(199) == 0);
      buf_valid      = ($urandom_range(7) != 0);
      buf_busy       = ($urandom_range(5) == 0);
      id_ready       = ($urandom_range(3) != 0);
      redirect_valid = ($urandom_range(19) == 0);
      r = $urandom;
      redirect_pc    = ($urandom_range(3) == 0) ? {28'hFFFFFFF, r[3:0]} : r;
      r = $urandom;
      buf_ins        = ($urandom_range(3) == 0) ? {r[31:7], 7'b1101111} : r;
      step("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Fetch-stage PC sequencer and IF/ID holding register. It sits between the instruction buffer and decode: it drives the PC into the buffer, waits for a settled instruction, and captures it together with its PC. It then hands the pair to decode over a valid/ready handshake. Control-flow redirects from execute override everything.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC presented after reset.
- FETCH_LAT, 2, number of consecutive clean cycles (buffer valid, not busy) required before `buf_ins` is captured for the current PC. Legal range is 1..7.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- pc_out  out  32  fetch PC to the buffer's PC input; registered.
- buf_ins  in  32  instruction word from the buffer.
- buf_valid  in  1  buffer holds a valid window.
- buf_busy  in  1  buffer is refilling; `buf_ins` is not trustworthy.
- redirect_valid  in  1  one-cycle request from execute to restart fetch.
- redirect_pc  in  32  redirect target.
- id_valid  out  1  `id_ins`/`id_pc` hold a fetched instruction.
- id_ready  in  1  decode accepts this cycle.
- id_ins  out  32  captured instruction.
- id_pc  out  32  PC of `id_ins`.
- id_pred_taken  out  1  next PC came from predecode (see Configuration).
- pc_misalign  out  1  one-cycle pulse, registered: the last redirect had `redirect_pc[1:0]` != 0.

## Operation
- States: RST_WAIT, WAIT, HOLD.
- Reset state: RST_WAIT. Reset outputs:
  - pc_out = RESET_PC
  - id_valid = 0, id_ins = 32'h0000_0013, id_pc = 0
  - id_pred_taken = 0, pc_misalign = 0, settle counter = 0
- RST_WAIT:
  - Lasts exactly one cycle, then goes to WAIT.
- WAIT:
  - Counter `cnt` (3 bits) increments each cycle that `buf_valid && !buf_busy`.
  - Any cycle with `!buf_valid || buf_busy` clears `cnt` to 0.
  - When `cnt == FETCH_LAT-1` and the current cycle is clean: capture `buf_ins` into `id_ins`, capture `pc_out` into `id_pc`, set `id_valid`, go to HOLD.
  - At the same edge, `pc_out` takes the next PC: `pc_out + 4`, or the predecode target.
- HOLD:
  - `id_*` are held stable while `id_valid && !id_ready`.
  - On `id_valid && id_ready`: clear `id_valid`, clear `cnt`, go to WAIT.
- Redirect has highest priority in every state, including RST_WAIT:
  - pc_out <= {redirect_pc[31:2], 2'b00}
  - id_valid <= 0, cnt <= 0, state <= WAIT
  - pc_misalign <= |redirect_pc[1:0]
- Redirect in the same cycle as a handshake: the transfer counts as done for decode, but the fetch stage discards its own next PC and takes the redirect.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
- `buf_busy` rising while in HOLD does not disturb the `id_*` outputs.

## Timing
- Best case is one instruction every FETCH_LAT+1 cycles (3 at default) when `id_ready` is held high.
- First `id_valid` after reset deasserts: cycle 1 + FETCH_LAT at the earliest, given clean buffer inputs.
- Redirect to first `id_valid`: FETCH_LAT cycles minimum.
- `id_valid` rises on the same edge as the `pc_out` advance.
- `pc_misalign` stays high for exactly one cycle after the redirect edge.
- No combinational path from any input to any output.

## Configuration
- FETCH_PREDECODE_EN defined:
  - At capture, if `buf_ins[6:0] == 7'b1101111` (JAL), next PC = capture PC + sign-extended J-immediate, and `id_pred_taken` = 1 alongside `id_valid`.
  - Otherwise the next PC is +4 and `id_pred_taken` = 0.
- FETCH_PREDECODE_EN undefined:
  - Next PC is always +4.
  - `id_pred_taken` is tied to 0.
  - The port remains present.

## Structure
- Shared package `fetch_pkg` holds:
  - the state encoding (RST_WAIT/WAIT/HOLD)
  - OPC_JAL = 7'b1101111
  - NOP_INS = 32'h0000_0013
- Sub-module `jal_predecoder`, combinational:
  - Inputs: instruction, PC.
  - Outputs: is_jal, target.
  - Instantiated only under FETCH_PREDECODE_EN.

## Test plan
- Reset: hold rst 3 cycles and release.
  - Expect pc_out = 0x0, id_valid = 0, id_ins = 0x00000013 until the first capture.
- Steady stream: buf_valid = 1, buf_busy = 0, id_ready = 1, buf_ins = 0x00000013.
  - Expect id_pc = 0x0, 0x4, 0x8, with id_valid pulses 3 cycles apart.
- Busy glitch: assert buf_busy for one cycle during WAIT at cnt = 1.
  - Expect capture delayed by 2 cycles; id_pc unchanged.
- Backpressure: id_ready = 0 for 5 cycles in HOLD.
  - Expect id_ins/id_pc constant and pc_out constant; one handshake when id_ready rises.
- Redirect: redirect_valid with redirect_pc = 0x103 during HOLD.
  - Expect next cycle id_valid = 0, pc_out = 0x100, pc_misalign = 1 for one cycle.
  - First new capture has id_pc = 0x100.
- Predecode, with FETCH_PREDECODE_EN defined: buf_ins = 0x0080006F captured at PC 0x10.
  - Expect id_pred_taken = 1 and next id_pc = 0x18.
  - With the macro undefined: expect next id_pc = 0x14 and id_pred_taken = 0.
